// File: rtl/icache_pkg.sv
// ============================================================================
// icache_pkg : shared state encoding and address-field widths for icache_l1
// Revision   : 1.0
// ============================================================================
`default_nettype none

package icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REFILL  = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  function automatic int off_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int lines, input int words_per_line);
    return addr_w - 2 - $clog2(lines) - $clog2(words_per_line);
  endfunction

endpackage

`default_nettype wire

// File: rtl/icache_ram.sv
// ============================================================================
// icache_ram : single-write-port RAM with registered (synchronous) read
// Revision   : 1.0
// ============================================================================
`default_nettype none

module icache_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule

`default_nettype wire

// File: rtl/icache_l1.sv
// ============================================================================
// icache_l1 : direct-mapped L1 instruction cache with line refill, kill, inv
// Revision  : 1.0
// ============================================================================
`default_nettype none

module icache_l1
  import icache_pkg::*;
#(
  parameter int LINES          = 64,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              req_kill,
  input  logic              inv,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_ren,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_done
);

  localparam int OFF_W = off_w(WORDS_PER_LINE);
  localparam int IDX_W = idx_w(LINES);
  localparam int TAG_W = tag_w(ADDR_W, LINES, WORDS_PER_LINE);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LINES-1:0]   r_valid;
  logic               r_lk;
  logic [TAG_W-1:0]   r_lk_tag;
  logic [IDX_W-1:0]   r_lk_idx;
  logic [OFF_W-1:0]   r_lk_off;
  logic [OFF_W-1:0]   r_beat;
  logic               r_fill_last;
  logic               r_kill;
  logic               r_inv_pend;
  logic [31:0]        r_word;

  logic [TAG_W-1:0]   w_req_tag;
  logic [IDX_W-1:0]   w_req_idx;
  logic [OFF_W-1:0]   w_req_off;
  logic [TAG_W-1:0]   w_tag_rdata;
  logic [31:0]        w_data_rdata;
  logic               w_hit;
  logic               w_miss;
  logic               w_accept;
  logic               w_beat_done;
  logic               w_install;
  logic               w_unused_addr_lsbs;

  assign w_req_off = req_addr[2 +: OFF_W];
  assign w_req_idx = req_addr[2 + OFF_W +: IDX_W];
  assign w_req_tag = req_addr[ADDR_W-1 -: TAG_W];
  assign w_unused_addr_lsbs = ^req_addr[1:0];

  // An inv in the lookup cycle forces a miss so a just-invalidated line is never served.
  assign w_hit       = r_lk && r_valid[r_lk_idx] && (w_tag_rdata == r_lk_tag) && !inv;
  assign w_miss      = r_lk && !w_hit;
  assign w_accept    = req_valid && req_ready;
  assign w_beat_done = (r_state == ST_REFILL) && !r_fill_last && bus_done;
  // One install cycle after the last beat commits tag and valid bit.
  assign w_install   = (r_state == ST_REFILL) && r_fill_last;

  icache_ram #(
    .DEPTH (LINES * WORDS_PER_LINE),
    .WIDTH (32),
    .AW    (IDX_W + OFF_W)
  ) u_data_ram (
    .clk     (clk),
    .i_we    (w_beat_done),
    .i_waddr ({r_lk_idx, r_beat}),
    .i_wdata (bus_rdata),
    .i_raddr ({w_req_idx, w_req_off}),
    .o_rdata (w_data_rdata)
  );

  icache_ram #(
    .DEPTH (LINES),
    .WIDTH (TAG_W),
    .AW    (IDX_W)
  ) u_tag_ram (
    .clk     (clk),
    .i_we    (w_install),
    .i_waddr (r_lk_idx),
    .i_wdata (r_lk_tag),
    .i_raddr (w_req_idx),
    .o_rdata (w_tag_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_data    = '0;
    bus_ren     = 1'b0;
    bus_addr    = '0;
    unique case (r_state)
      ST_IDLE: begin
        req_ready = !w_miss && !inv;
        rsp_valid = w_hit && !req_kill;
        if (w_hit) begin
          rsp_data = w_data_rdata;
        end
        if (w_miss) begin
          w_state_nxt = ST_REFILL;
        end
      end
      ST_REFILL: begin
        if (r_fill_last) begin
          w_state_nxt = ST_RESPOND;
        end else begin
          bus_ren  = 1'b1;
          bus_addr = {r_lk_tag, r_lk_idx, r_beat, 2'b00};
        end
      end
      ST_RESPOND: begin
        rsp_valid   = !r_kill && !req_kill;
        rsp_data    = r_word;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lk     <= 1'b0;
      r_lk_tag <= '0;
      r_lk_idx <= '0;
      r_lk_off <= '0;
    end else begin
      r_lk <= w_accept;
      if (w_accept) begin
        r_lk_tag <= w_req_tag;
        r_lk_idx <= w_req_idx;
        r_lk_off <= w_req_off;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat      <= '0;
      r_fill_last <= 1'b0;
      r_word      <= '0;
    end else if (w_beat_done) begin
      r_beat <= r_beat + 1'b1;
      if (r_beat == r_lk_off) begin
        r_word <= bus_rdata;
      end
      if (&r_beat) begin
        r_fill_last <= 1'b1;
      end
    end else if (w_install) begin
      r_fill_last <= 1'b0;
    end
  end

  // Kill and inv seen during a refill are remembered until the RESPOND cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_kill     <= 1'b0;
      r_inv_pend <= 1'b0;
    end else begin
      if (r_state == ST_RESPOND) begin
        r_kill <= 1'b0;
      end else if (req_kill && (w_miss || r_state == ST_REFILL)) begin
        r_kill <= 1'b1;
      end
      if (r_state == ST_RESPOND) begin
        r_inv_pend <= 1'b0;
      end else if (inv && r_state != ST_IDLE) begin
        r_inv_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
    end else if ((inv && r_state == ST_IDLE) ||
                 (r_state == ST_RESPOND && (r_inv_pend || inv))) begin
      r_valid <= '0;
    end else if (w_install && !r_inv_pend && !inv) begin
      r_valid[r_lk_idx] <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_icache_l1.sv
// ============================================================================
// tb_icache_l1 : scoreboard bench for icache_l1 with a fixed-latency bus model
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_icache_l1;

  localparam int LINES    = 64;
  localparam int WPL      = 4;
  localparam int AW       = 32;
  localparam int BL       = 2;
  localparam int LAT_HIT  = 1;
  localparam int LAT_MISS = WPL * BL + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic          req_ready;
  logic          req_kill = 1'b0;
  logic          inv = 1'b0;
  logic          rsp_valid;
  logic [31:0]   rsp_data;
  logic [AW-1:0] bus_addr;
  logic          bus_ren;
  logic [31:0]   bus_rdata = '0;
  logic          bus_done = 1'b0;

  typedef struct {
    logic [31:0] data;
    int          due;
    logic [31:0] addr;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] beats[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          bcnt = 0;
  logic [31:0] beat_addr = '0;

  icache_l1 #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WPL),
    .ADDR_W         (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .req_kill  (req_kill),
    .inv       (inv),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .bus_addr  (bus_addr),
    .bus_ren   (bus_ren),
    .bus_rdata (bus_rdata),
    .bus_done  (bus_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // Backing memory: each beat completes after BL cycles of bus_ren.
  always @(negedge clk) begin
    if (!bus_ren) begin
      bcnt     = 0;
      bus_done = 1'b0;
    end else begin
      if (bcnt == 0) begin
        beat_addr = bus_addr;
      end else if (bus_addr !== beat_addr) begin
        n_chk++;
        n_fail++;
        $display("FAIL bus_addr_stable: bus_addr=%h required %h", bus_addr, beat_addr);
      end
      bcnt++;
      bus_rdata = mem_word(bus_addr);
      if (bcnt == BL) begin
        bus_done = 1'b1;
        bcnt     = 0;
        beats.push_back(bus_addr);
      end else begin
        bus_done = 1'b0;
      end
    end
  end

  // Response monitor: pops the scoreboard and checks data and arrival cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (rsp_valid) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rsp: rsp_valid=1 data=%h at cycle %0d, required no response", rsp_data, cyc);
        end else begin
          mon_e = sb.pop_front();
          if (rsp_data !== mon_e.data || cyc != mon_e.due) begin
            n_fail++;
            $display("FAIL rsp_%h: data=%h cycle=%0d, required data=%h cycle=%0d",
                     mon_e.addr, rsp_data, cyc, mon_e.data, mon_e.due);
          end
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        n_chk++;
        n_fail++;
        mon_e = sb.pop_front();
        $display("FAIL missing_rsp_%h: no response by cycle %0d, required data=%h at cycle %0d",
                 mon_e.addr, cyc, mon_e.data, mon_e.due);
      end
    end
  end

  task automatic issue(input logic [31:0] a, input int lat, input bit expect_rsp);
    int t;
    t = 0;
    req_valid = 1'b1;
    req_addr  = a;
    @(negedge clk);
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL req_ready_timeout_%h: req_ready=0 after 100 cycles, required 1", a);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (expect_rsp) sb.push_back('{data: mem_word({a[31:2], 2'b00}), due: cyc - 1 + lat, addr: a});
  endtask

  task automatic drain();
    int t;
    t = 0;
    @(negedge clk);
    while ((sb.size() != 0 || !req_ready) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: pending=%0d req_ready=%b, required 0 pending and ready", sb.size(), req_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_inv();
    inv = 1'b1;
    @(posedge clk);
    #1;
    inv = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    n_chk += 4;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: %b required 0", rsp_valid); end
    if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data: %h required 0", rsp_data); end
    if (bus_ren !== 1'b0) begin n_fail++; $display("FAIL reset_bus_ren: %b required 0", bus_ren); end
    if (bus_addr !== 32'h0) begin n_fail++; $display("FAIL reset_bus_addr: %h required 0", bus_addr); end
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: %b required 1", req_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_cold_miss();
    logic [31:0] exp_b [4];
    exp_b = '{32'h10, 32'h14, 32'h18, 32'h1C};
    beats.delete();
    issue(32'h10, LAT_MISS, 1'b1);
    drain();
    n_chk++;
    if (beats.size() != 4) begin
      n_fail++;
      $display("FAIL cold_beat_count: %0d required 4", beats.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_chk++;
        if (beats[i] !== exp_b[i]) begin
          n_fail++;
          $display("FAIL cold_beat_addr_%0d: %h required %h", i, beats[i], exp_b[i]);
        end
      end
    end
    issue(32'h14, LAT_HIT, 1'b1);
    drain();
  endtask

  task automatic test_critical_word();
    pulse_inv();
    beats.delete();
    issue(32'h1C, LAT_MISS, 1'b1);
    drain();
    n_chk++;
    if (beats.size() != 4 || beats[0] !== 32'h10) begin
      n_fail++;
      $display("FAIL critical_first_beat: count=%0d, required 4 beats starting at 00000010", beats.size());
    end
    issue(32'h10, LAT_HIT, 1'b1);
    drain();
  endtask

  task automatic test_conflict();
    issue(32'h0, LAT_MISS, 1'b1);
    drain();
    issue(32'h400, LAT_MISS, 1'b1);
    drain();
    issue(32'h0, LAT_MISS, 1'b1);
    drain();
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = 32'(i * 4);
      @(negedge clk);
      n_chk++;
      if (req_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready_%0d: %b required 1", i, req_ready);
      end
      @(posedge clk);
      #1;
      sb.push_back('{data: mem_word(32'(i * 4)), due: cyc - 1 + LAT_HIT, addr: 32'(i * 4)});
    end
    req_valid = 1'b0;
    drain();
  endtask

  task automatic test_kill();
    beats.delete();
    issue(32'h20, 0, 1'b0);
    req_kill = 1'b1;
    @(posedge clk);
    #1;
    req_kill = 1'b0;
    drain();
    n_chk++;
    if (beats.size() != 4) begin
      n_fail++;
      $display("FAIL kill_refill_beats: %0d required 4", beats.size());
    end
    issue(32'h24, LAT_HIT, 1'b1);
    drain();
    issue(32'h28, 0, 1'b0);
    req_kill = 1'b1;
    @(posedge clk);
    #1;
    req_kill = 1'b0;
    drain();
  endtask

  task automatic test_inv();
    issue(32'h30, LAT_MISS, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    pulse_inv();
    drain();
    issue(32'h30, LAT_MISS, 1'b1);
    drain();
    issue(32'h10, LAT_MISS, 1'b1);
    drain();
    issue(32'h30, LAT_HIT, 1'b1);
    drain();
    pulse_inv();
    issue(32'h30, LAT_MISS, 1'b1);
    drain();
  endtask

  task automatic test_async_reset();
    int t;
    t = 0;
    beats.delete();
    issue(32'h40, 0, 1'b0);
    while (beats.size() < 2 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (beats.size() < 2) begin
      n_chk++;
      n_fail++;
      $display("FAIL areset_beat_wait: %0d beats, required 2", beats.size());
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_chk += 2;
    if (bus_ren !== 1'b0) begin n_fail++; $display("FAIL areset_bus_ren: %b required 0", bus_ren); end
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL areset_rsp_valid: %b required 0", rsp_valid); end
    @(posedge clk);
    #2;
    rst = 1'b1;
    drain();
    issue(32'h30, LAT_MISS, 1'b1);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_critical_word();
    test_conflict();
    test_back_to_back();
    test_kill();
    test_inv();
    test_async_reset();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
